// File: rtl/circle_pkg.sv
// Shared types and defaults for the parametrised midpoint circle drawer.
package circle_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        PLOT,
        STEP,
        DONE
    } state_t;

    typedef logic [2:0] octant_t;
    typedef logic [1:0] span_t;

    localparam int DEFAULT_SCREEN_W = 160;
    localparam int DEFAULT_SCREEN_H = 120;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/circle_draw_param_if.sv
// Request/response and VGA write-port bundle between task FSM, drawer and vga_adapter.
interface circle_draw_param_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int R_W      = 8,
    parameter int COLOUR_W = 3
);

    logic                start;
    logic                fill;
    logic [COLOUR_W-1:0] colour;
    logic [X_W-1:0]      centre_x;
    logic [Y_W-1:0]      centre_y;
    logic [R_W-1:0]      radius;
    logic                done;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;

    modport master (
        output start, fill, colour, centre_x, centre_y, radius,
        input  done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  start, fill, colour, centre_x, centre_y, radius,
        output done, vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/circle_clip.sv
// Combinational on-screen test for a signed (x, y) candidate pixel.
module circle_clip
    import circle_pkg::*;
#(
    parameter int SCREEN_W = DEFAULT_SCREEN_W,
    parameter int SCREEN_H = DEFAULT_SCREEN_H,
    parameter int CW       = 10
) (
    input  logic signed [CW-1:0] x,
    input  logic signed [CW-1:0] y,
    output logic                 in_bounds
);

    localparam logic signed [CW-1:0] W_LIM = CW'(SCREEN_W);
    localparam logic signed [CW-1:0] H_LIM = CW'(SCREEN_H);

    assign in_bounds = !x[CW-1] && !y[CW-1] && (x < W_LIM) && (y < H_LIM);

endmodule

// File: rtl/circle_draw_param.sv
// Midpoint circle rasteriser (outline or filled disc), one candidate pixel per clock.
// Optional CIRCLE_PIXEL_COUNT_EN adds a pix_count output counting written pixels.
module circle_draw_param
    import circle_pkg::*;
#(
    parameter int SCREEN_W = DEFAULT_SCREEN_W,
    parameter int SCREEN_H = DEFAULT_SCREEN_H,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int R_W      = 8,
    parameter int COLOUR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    circle_draw_param_if.slave bus
`ifdef CIRCLE_PIXEL_COUNT_EN
    ,
    output logic [2*R_W+3:0]   pix_count
`endif
);

    localparam int CW = max2(X_W, Y_W) + 2;
    localparam int OW = R_W + 2;
    localparam int KW = R_W + 3;

    typedef logic signed [CW-1:0] coord_t;
    typedef logic signed [OW-1:0] off_t;
    typedef logic signed [KW-1:0] crit_t;

    state_t              state, state_d;
    logic                fill_q;
    logic [COLOUR_W-1:0] colour_q;
    coord_t              cx_q, cy_q;
    off_t                ox, oy;
    crit_t               crit;
    octant_t             oct;
    span_t               span;
    coord_t              px;

    coord_t oxc, oyc, half, xl_next, cand_x, cand_y;
    span_t  span_nx;
    logic   span_end, last_plot, in_bounds;
    off_t   ox_step, oy_step;
    crit_t  crit_diff, crit_step;

    // Candidate pixel for the current PLOT cycle, plus the next midpoint step.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        oxc      = coord_t'(ox);
        oyc      = coord_t'(oy);
        span_nx  = span + 2'd1;
        half     = span[1] ? oyc : oxc;
        xl_next  = cx_q - (span_nx[1] ? oyc : oxc);
        span_end = (px == cx_q + half);
        cand_x   = '0;
        cand_y   = '0;

        if (fill_q) begin
            cand_x = px;
            case (span)
                2'd0: cand_y = cy_q + oyc;
                2'd1: cand_y = cy_q - oyc;
                2'd2: cand_y = cy_q + oxc;
                2'd3: cand_y = cy_q - oxc;
            endcase
        end else begin
            case (oct)
                3'd0: begin cand_x = cx_q + oxc; cand_y = cy_q + oyc; end
                3'd1: begin cand_x = cx_q + oyc; cand_y = cy_q + oxc; end
                3'd2: begin cand_x = cx_q - oyc; cand_y = cy_q + oxc; end
                3'd3: begin cand_x = cx_q - oxc; cand_y = cy_q + oyc; end
                3'd4: begin cand_x = cx_q - oxc; cand_y = cy_q - oyc; end
                3'd5: begin cand_x = cx_q - oyc; cand_y = cy_q - oxc; end
                3'd6: begin cand_x = cx_q + oyc; cand_y = cy_q - oxc; end
                3'd7: begin cand_x = cx_q + oxc; cand_y = cy_q - oyc; end
            endcase
        end

        last_plot = fill_q ? (span_end && span == 2'd3) : (oct == 3'd7);

        oy_step = oy + off_t'(1);
        if (crit[KW-1] || crit == '0) begin
            ox_step   = ox;
            crit_diff = crit_t'(oy_step);
        end else begin
            ox_step   = ox - off_t'(1);
            crit_diff = crit_t'(oy_step) - crit_t'(ox_step);
        end
        crit_step = crit + (crit_diff <<< 1) + crit_t'(1);
    end

    circle_clip #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .CW       (CW)
    ) u_clip (
        .x         (cand_x),
        .y         (cand_y),
        .in_bounds (in_bounds)
    );

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (bus.start) state_d = INIT;
            INIT:    state_d = (oy <= ox) ? PLOT : DONE;
            PLOT:    if (last_plot) state_d = STEP;
            STEP:    state_d = (oy_step <= ox_step) ? PLOT : DONE;
            DONE:    if (!bus.start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q   <= 1'b0;
            colour_q <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            ox       <= '0;
            oy       <= '0;
            crit     <= '0;
            oct      <= '0;
            span     <= '0;
            px       <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    fill_q   <= bus.fill;
                    colour_q <= bus.colour;
                    cx_q     <= $signed({{(CW-X_W){1'b0}}, bus.centre_x});
                    cy_q     <= $signed({{(CW-Y_W){1'b0}}, bus.centre_y});
                    ox       <= $signed({2'b00, bus.radius});
                    oy       <= '0;
                    crit     <= crit_t'(1) - $signed({3'b000, bus.radius});
                end
                INIT: begin
                    oct  <= '0;
                    span <= '0;
                    px   <= cx_q - oxc;
                end
                PLOT: begin
                    if (fill_q) begin
                        if (span_end) begin
                            span <= span_nx;
                            px   <= xl_next;
                        end else begin
                            px <= px + coord_t'(1);
                        end
                    end else begin
                        oct <= oct + 3'd1;
                    end
                end
                STEP: begin
                    ox   <= ox_step;
                    oy   <= oy_step;
                    crit <= crit_step;
                    oct  <= '0;
                    span <= '0;
                    px   <= cx_q - coord_t'(ox_step);
                end
                default: ;
            endcase
        end
    end

    // Clipped candidates still burn their cycle but leave x/y/colour untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.vga_plot   <= 1'b0;
            bus.vga_x      <= '0;
            bus.vga_y      <= '0;
            bus.vga_colour <= '0;
            bus.done       <= 1'b0;
        end else begin
            bus.vga_plot <= 1'b0;
            if (state == PLOT && in_bounds) begin
                bus.vga_plot   <= 1'b1;
                bus.vga_x      <= cand_x[X_W-1:0];
                bus.vga_y      <= cand_y[Y_W-1:0];
                bus.vga_colour <= colour_q;
            end
            bus.done <= (state_d == DONE);
        end
    end

`ifdef CIRCLE_PIXEL_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                pix_count <= '0;
        else if (state == INIT) pix_count <= '0;
        else if (bus.vga_plot)  pix_count <= pix_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_circle_draw_param.sv
// Scoreboard bench for circle_draw_param: expected pixels queued per draw, popped on vga_plot.
module tb_circle_draw_param;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    circle_draw_param_if #(.X_W(8), .Y_W(7), .R_W(8), .COLOUR_W(3)) bus ();

`ifdef CIRCLE_PIXEL_COUNT_EN
    logic [19:0] pix_count;
`endif

    circle_draw_param #(
        .SCREEN_W (160),
        .SCREEN_H (120),
        .X_W      (8),
        .Y_W      (7),
        .R_W      (8),
        .COLOUR_W (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef CIRCLE_PIXEL_COUNT_EN
        ,
        .pix_count (pix_count)
`endif
    );

    int   checks   = 0;
    int   failures = 0;
    pix_t exp_q[$];
    bit   mon_en   = 1'b0;
    int   plot_cnt = 0;
    int   first_x  = -1;
    int   first_y  = -1;

    always @(negedge clk) begin
        if (mon_en && !rst && bus.vga_plot) begin
            pix_t got;
            pix_t exp;
            got = '{x: bus.vga_x, y: bus.vga_y, c: bus.vga_colour};
            if (plot_cnt == 0) begin
                first_x = int'(bus.vga_x);
                first_y = int'(bus.vga_y);
            end
            plot_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_plot got x=%0d y=%0d c=%0d required no plot",
                         got.x, got.y, got.c);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL pixel got x=%0d y=%0d c=%0d required x=%0d y=%0d c=%0d",
                             got.x, got.y, got.c, exp.x, exp.y, exp.c);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got no finish required finish");
        $fatal(1, "bench timeout");
    end

    task automatic push_pix(input int x, input int y, input logic [2:0] col);
        if (x >= 0 && x < 160 && y >= 0 && y < 120)
            exp_q.push_back('{x: 8'(x), y: 7'(y), c: col});
    endtask

    // Behavioural midpoint model; returns candidate and step counts for cycle checks.
    task automatic model_draw(input bit fl, input int cx, input int cy, input int r,
                              input logic [2:0] col, output int cand, output int steps);
        int ox, oy, d, h, row;
        int xs[8];
        int ys[8];
        cand = 0; steps = 0; ox = r; oy = 0; d = 1 - r;
        while (oy <= ox) begin
            steps++;
            if (!fl) begin
                xs = '{cx+ox, cx+oy, cx-oy, cx-ox, cx-ox, cx-oy, cx+oy, cx+ox};
                ys = '{cy+oy, cy+ox, cy+ox, cy+oy, cy-oy, cy-ox, cy-ox, cy-oy};
                for (int k = 0; k < 8; k++) begin
                    cand++;
                    push_pix(xs[k], ys[k], col);
                end
            end else begin
                for (int k = 0; k < 4; k++) begin
                    h   = (k < 2) ? ox : oy;
                    row = (k == 0) ? cy + oy : (k == 1) ? cy - oy : (k == 2) ? cy + ox : cy - ox;
                    for (int x = cx - h; x <= cx + h; x++) begin
                        cand++;
                        push_pix(x, row, col);
                    end
                end
            end
            oy++;
            if (d <= 0) d += 2*oy + 1;
            else begin
                ox--;
                d += 2*(oy - ox) + 1;
            end
        end
    endtask

    task automatic run_draw(input bit fl, input logic [2:0] col, input int cx, input int cy,
                            input int r, input int exp_cycles, input int hold,
                            input bit drop_start, input string name);
        int cyc;
        bit got_done;
        plot_cnt = 0;
        mon_en   = 1'b1;
        @(negedge clk);
        bus.fill     = fl;
        bus.colour   = col;
        bus.centre_x = 8'(cx);
        bus.centre_y = 7'(cy);
        bus.radius   = 8'(r);
        bus.start    = 1'b1;
        cyc = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (drop_start && cyc == 3) begin
                bus.start    = 1'b0;
                bus.radius   = 8'd77;
                bus.centre_x = 8'd3;
                bus.colour   = ~col;
            end
            if (bus.done) got_done = 1'b1;
        end
        checks++;
        if (cyc != exp_cycles) begin
            failures++;
            $display("FAIL %s_cycles got %0d required %0d", name, cyc, exp_cycles);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b1) begin
                failures++;
                $display("FAIL %s_done_hold got %b required 1", name, bus.done);
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_clear got %b required 0", name, bus.done);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing got %0d unplotted required 0", name, exp_q.size());
        end
        exp_q.delete();
        mon_en = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.fill = 1'b0; bus.colour = '0;
        bus.centre_x = '0; bus.centre_y = '0; bus.radius = '0;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.vga_plot, bus.done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags got plot=%b done=%b required 0 0", bus.vga_plot, bus.done);
        end
        checks++;
        if ({bus.vga_x, bus.vga_y, bus.vga_colour} !== 18'd0) begin
            failures++;
            $display("FAIL reset_pixel got x=%0d y=%0d c=%0d required 0 0 0",
                     bus.vga_x, bus.vga_y, bus.vga_colour);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL idle_done got %b required 0", bus.done);
        end
    endtask

    task automatic test_outline_r0();
        int cand, steps;
        model_draw(1'b0, 80, 60, 0, 3'd2, cand, steps);
        run_draw(1'b0, 3'd2, 80, 60, 0, 11, 3, 1'b0, "outline_r0");
        checks++;
        if (plot_cnt != 8) begin
            failures++;
            $display("FAIL outline_r0_plots got %0d required 8", plot_cnt);
        end
    endtask

    task automatic test_outline_r1();
        int xs[16] = '{81,80,80,79,79,80,80,81, 81,81,79,79,79,79,81,81};
        int ys[16] = '{60,61,61,60,60,59,59,60, 61,61,61,61,59,59,59,59};
        for (int i = 0; i < 16; i++) push_pix(xs[i], ys[i], 3'd5);
        run_draw(1'b0, 3'd5, 80, 60, 1, 20, 0, 1'b0, "outline_r1");
        checks++;
        if (plot_cnt != 16) begin
            failures++;
            $display("FAIL outline_r1_plots got %0d required 16", plot_cnt);
        end
`ifdef CIRCLE_PIXEL_COUNT_EN
        checks++;
        if (pix_count !== 20'd16) begin
            failures++;
            $display("FAIL pix_count got %0d required 16", pix_count);
        end
`endif
    endtask

    task automatic test_clip();
        int cand, steps;
        model_draw(1'b0, 0, 0, 10, 3'd7, cand, steps);
        run_draw(1'b0, 3'd7, 0, 0, 10, cand + steps + 2, 0, 1'b0, "clip_r10");
        checks++;
        if (first_x != 10 || first_y != 0) begin
            failures++;
            $display("FAIL clip_first got (%0d,%0d) required (10,0)", first_x, first_y);
        end
        model_draw(1'b0, 80, 60, 10, 3'd7, cand, steps);
        run_draw(1'b0, 3'd7, 80, 60, 10, cand + steps + 2, 0, 1'b0, "noclip_r10");
    endtask

    task automatic test_filled_r1();
        int xs[20] = '{4,5,6, 4,5,6, 5, 5, 4,5,6, 4,5,6, 4,5,6, 4,5,6};
        int ys[20] = '{5,5,5, 5,5,5, 6, 4, 6,6,6, 4,4,4, 6,6,6, 4,4,4};
        for (int i = 0; i < 20; i++) push_pix(xs[i], ys[i], 3'd3);
        run_draw(1'b1, 3'd3, 5, 5, 1, 24, 0, 1'b0, "filled_r1");
        checks++;
        if (plot_cnt != 20) begin
            failures++;
            $display("FAIL filled_r1_plots got %0d required 20", plot_cnt);
        end
    endtask

    task automatic test_filled_misc();
        int cand, steps;
        model_draw(1'b1, 80, 60, 0, 3'd1, cand, steps);
        run_draw(1'b1, 3'd1, 80, 60, 0, 7, 0, 1'b0, "filled_r0");
        checks++;
        if (plot_cnt != 4) begin
            failures++;
            $display("FAIL filled_r0_plots got %0d required 4", plot_cnt);
        end
        model_draw(1'b1, 158, 2, 3, 3'd6, cand, steps);
        run_draw(1'b1, 3'd6, 158, 2, 3, cand + steps + 2, 0, 1'b1, "filled_corner_drop");
    endtask

    task automatic test_large_radius();
        int cand, steps;
        model_draw(1'b0, 80, 60, 200, 3'd4, cand, steps);
        run_draw(1'b0, 3'd4, 80, 60, 200, cand + steps + 2, 0, 1'b0, "large_r");
        checks++;
        if (plot_cnt != 0) begin
            failures++;
            $display("FAIL large_r_plots got %0d required 0", plot_cnt);
        end
    endtask

    task automatic test_reset_mid_draw();
        int seen, cand, steps;
        mon_en = 1'b0;
        seen   = 0;
        @(negedge clk);
        bus.fill = 1'b0; bus.colour = 3'd2; bus.centre_x = 8'd80;
        bus.centre_y = 7'd60; bus.radius = 8'd40; bus.start = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.vga_plot) seen++;
        end
        checks++;
        if (seen == 0) begin
            failures++;
            $display("FAIL pre_reset_plots got 0 required >0");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.vga_plot, bus.done} !== 2'b00) begin
            failures++;
            $display("FAIL async_reset got plot=%b done=%b required 0 0", bus.vga_plot, bus.done);
        end
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b0;
        model_draw(1'b0, 80, 60, 2, 3'd5, cand, steps);
        run_draw(1'b0, 3'd5, 80, 60, 2, cand + steps + 2, 0, 1'b0, "after_reset_r2");
    endtask

    task automatic test_back_to_back();
        int cand, steps;
        model_draw(1'b0, 10, 100, 2, 3'd1, cand, steps);
        run_draw(1'b0, 3'd1, 10, 100, 2, cand + steps + 2, 0, 1'b0, "b2b_outline");
        model_draw(1'b1, 150, 110, 2, 3'd6, cand, steps);
        run_draw(1'b1, 3'd6, 150, 110, 2, cand + steps + 2, 0, 1'b0, "b2b_filled");
    endtask

    initial begin
        test_reset();
        test_outline_r0();
        test_outline_r1();
        test_clip();
        test_filled_r1();
        test_filled_misc();
        test_large_radius();
        test_reset_mid_draw();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/circle_draw_param.md
Name: circle_draw_param

Overview:
Parametrised successor to the lab circle drawer. Rasterises a circle with the midpoint (Bresenham) algorithm and streams one pixel per clock to the VGA adapter write port. Adds configurable screen/coordinate/colour widths, an outline or filled mode, and proper clipping with signed arithmetic. Sits between the top-level task FSM and the vga_adapter instance.

Parameters:
SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are clipped
SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are clipped
X_W, 8, width of x coordinates and centre_x
Y_W, 7, width of y coordinates and centre_y
R_W, 8, radius width
COLOUR_W, 3, colour width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  level request; sampled in IDLE
fill  in  1  0 = outline, 1 = filled disc; latched at start
colour  in  COLOUR_W  draw colour; latched at start
centre_x  in  X_W  centre x; latched at start
centre_y  in  Y_W  centre y; latched at start
radius  in  R_W  radius; latched at start
done  out  1  completion flag
vga_x  out  X_W  pixel x
vga_y  out  Y_W  pixel y
vga_colour  out  COLOUR_W  pixel colour
vga_plot  out  1  write strobe, one pixel per asserted cycle

Behaviour:
- Reset (async, any state): state=IDLE; done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
- States: IDLE -> INIT -> PLOT -> (STEP -> PLOT)* -> DONE -> IDLE.
- IDLE: when start=1, latch all inputs and go to INIT. Set ox=radius, oy=0, crit=1-radius.
- INIT: one cycle with no plot. Go to PLOT if oy<=ox.
- PLOT outline: 8 cycles per step, octant order:
  (cx+ox,cy+oy), (cx+oy,cy+ox), (cx-oy,cy+ox), (cx-ox,cy+oy), (cx-ox,cy-oy), (cx-oy,cy-ox), (cx+oy,cy-ox), (cx+ox,cy-oy).
  Duplicates (oy=0 or oy=ox) are still emitted.
- PLOT filled: 4 horizontal spans per step, each walked left to right one pixel per cycle:
  - row cy+oy, x from cx-ox to cx+ox
  - row cy-oy, same x range
  - row cy+ox, x from cx-oy to cx+oy
  - row cy-ox, same x range
- STEP: one cycle, no plot.
  - oy<=oy+1.
  - If crit<=0: crit<=crit+2*oy_new+1.
  - Else: ox<=ox-1 and crit<=crit+2*(oy_new-ox_new)+1.
  - Then, if oy_new<=ox_new go to PLOT, else DONE.
- Arithmetic: coordinates are computed signed, width max(X_W,Y_W)+2; crit is signed, R_W+3.
- Clipping: a candidate pixel with x<0, y<0, x>=SCREEN_W or y>=SCREEN_H still consumes its cycle but drives vga_plot=0. vga_x/vga_y then hold their previous values.
- Outputs are registered. vga_x/vga_y/vga_colour are valid in the same cycle vga_plot=1.
- DONE: done=1 and vga_plot=0. Stay in DONE while start=1. When start=0, done<=0 next cycle and return to IDLE.
- start falling mid-draw is ignored; the draw completes.
- radius=0: single step; outline gives 8 plots of (cx,cy), filled gives 4.
- A radius so large that every pixel is clipped still terminates normally, with no vga_plot pulses.

Optional Feature:
CIRCLE_PIXEL_COUNT_EN
- Defined: adds output pix_count (width 2*R_W+4). Cleared on reset and at INIT; incremented on every vga_plot=1 cycle; holds its value through DONE.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package circle_pkg holds:
  - state enum (IDLE, INIT, PLOT, STEP, DONE)
  - octant index typedef (3 bits)
  - span index typedef (2 bits)
  - default screen constants 160/120
- One sub-module, circle_clip: combinational signed (x,y) in-bounds check, parametrised by SCREEN_W/SCREEN_H. Used for the plot gating.

Test Plan:
- Outline, r=0, centre (80,60), start held: INIT, then 8 plots all at (80,60), then done=1 and held; start=0 -> done=0 next cycle.
- Outline, r=1, centre (80,60): exactly 16 plot cycles.
  - Step 1: (81,60),(80,61),(80,61),(79,60),(79,60),(80,59),(80,59),(81,60).
  - Step 2: the 8 diagonal points (81/79, 61/59), each emitted twice.
- Clipping, outline, r=10, centre (0,0): no vga_plot with negative coordinates; first plotted pixel is (10,0); total step/cycle count matches the unclipped case.
- Filled, r=1, centre (5,5):
  - Step 1: spans y=5 x4..6, y=5 x4..6, y=6 x5, y=4 x5.
  - Step 2: spans y=6 x4..6, y=4 x4..6, twice each.
  - Every written pixel lies within the 3x3 block.
- Reset asserted mid-PLOT with r=40: vga_plot and done drop to 0 immediately (async). After release, a new start with r=2 produces the correct fresh sequence.
- With CIRCLE_PIXEL_COUNT_EN, outline r=1 at (80,60): pix_count=16 at done.
